// File: rtl/bfp_deconverter.sv
// rtl/bfp_deconverter.sv - BFP group to per-element normalized FP expander
// Accepts one shared-exponent group per handshake and streams GRPSIZE FP elements out.
module bfp_deconverter #(
  parameter int GRPSIZE    = 16,
  parameter int FPEXPSIZE  = 8,
  parameter int FPMANSIZE  = 23,
  parameter int BFPEXPSIZE = 8,
  parameter int BFPMANSIZE = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [BFPEXPSIZE-1:0]        i_bfp_exp,
  input  logic [BFPMANSIZE:0]          i_bfps [0:GRPSIZE-1],
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [FPEXPSIZE-1:0]         o_exp,
  output logic [FPMANSIZE:0]           o_man,
  output logic [$clog2(GRPSIZE)-1:0]   o_idx,
  output logic                         o_last
);

  localparam int IDXW = $clog2(GRPSIZE);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]            state;
  logic [IDXW-1:0]       idx;
  logic [BFPEXPSIZE-1:0] grp_exp;
  logic [BFPMANSIZE:0]   grp_elem [0:GRPSIZE-1];

  logic                  accept;
  logic                  at_last;
  logic                  cur_sign;
  logic [BFPMANSIZE-1:0] cur_m;
  logic [BFPEXPSIZE:0]   lead_k;
  logic                  flush;
  logic [FPEXPSIZE-1:0]  norm_exp;
  logic [FPMANSIZE-1:0]  norm_man;

  assign o_valid = (state == S_DRAIN);
  assign at_last = (idx == IDXW'(GRPSIZE - 1));
  assign i_ready = (state == S_IDLE) | (o_valid & o_ready & at_last);
  assign accept  = i_valid & i_ready;

  // k = 1 + leading zeros of m; the highest set bit wins because it is visited last
  always_comb begin
    cur_sign = grp_elem[idx][BFPMANSIZE];
    cur_m    = grp_elem[idx][BFPMANSIZE-1:0];
    lead_k   = (BFPEXPSIZE+1)'(BFPMANSIZE);
    for (int b = 0; b < BFPMANSIZE; b++) begin
      if (cur_m[b]) lead_k = (BFPEXPSIZE+1)'(BFPMANSIZE - b);
    end
  end

  // Anything that would need a denormal is flushed to a signed zero
  always_comb begin
    flush    = (cur_m == '0) | (grp_exp == '0) | ({1'b0, grp_exp} <= lead_k);
    norm_exp = FPEXPSIZE'({1'b0, grp_exp} - lead_k);
    norm_man = (FPMANSIZE'(cur_m) << (FPMANSIZE - BFPMANSIZE)) << lead_k;
  end

  always_comb begin
    o_exp  = '0;
    o_man  = '0;
    o_idx  = '0;
    o_last = 1'b0;
    if (o_valid) begin
      o_idx  = idx;
      o_last = at_last;
      if (flush) begin
        o_man = {cur_sign, {FPMANSIZE{1'b0}}};
      end else begin
        o_exp = norm_exp;
        o_man = {cur_sign, norm_man};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else if (accept) begin
      state <= S_DRAIN;
      idx   <= '0;
    end else if (o_valid && o_ready) begin
      if (at_last) begin
        state <= S_IDLE;
        idx   <= '0;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && accept) begin
      grp_exp <= i_bfp_exp;
      for (int g = 0; g < GRPSIZE; g++) begin
        grp_elem[g] <= i_bfps[g];
      end
    end
  end

endmodule

// File: tb/tb_bfp_deconverter.sv
// tb/tb_bfp_deconverter.sv - self-checking bench for bfp_deconverter
// Table vectors, hand sequences for stall/back-to-back/reset, and randomized scoreboard runs.
module tb_bfp_deconverter;

  localparam int G  = 16;
  localparam int FM = 23;
  localparam int BM = 3;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  i_bfp_exp;
  logic [3:0]  i_bfps [0:G-1];
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_exp;
  logic [23:0] o_man;
  logic [3:0]  o_idx;
  logic        o_last;

  bfp_deconverter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_bfp_exp(i_bfp_exp), .i_bfps(i_bfps), .o_valid(o_valid), .o_ready(o_ready),
    .o_exp(o_exp), .o_man(o_man), .o_idx(o_idx), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] word; int idx; } exp_t;
  typedef struct { logic [7:0] e; logic [3:0] el; logic [31:0] word; } vec_t;

  exp_t        exp_q[$];
  logic [31:0] seen_q[$];
  vec_t        vecs[$];
  int tests = 0, fails = 0;
  int cyc = 0, vcount = 0, vfirst = -1, vlast = -1, rdy_pulses = 0;
  logic accepted = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_word;
  logic [3:0]  prev_idx;
  logic        prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value 0.m * 2^(E-bias) renormalized to 1.f * 2^(e-bias)
  function automatic logic [31:0] expand(input logic [7:0] e, input logic [3:0] el);
    int m, p, k;
    logic s;
    s = el[3];
    m = int'(el[2:0]);
    if (e == 0 || m == 0) return {s, 31'd0};
    p = BM - 1;
    while (m < (1 << p)) p--;
    k = BM - p;
    if (int'(e) <= k) return {s, 31'd0};
    return {s, 8'(int'(e) - k), 23'((m - (1 << p)) * (1 << (FM - p)))};
  endfunction

  task automatic monitor();
    logic [31:0] word;
    exp_t x;
    logic hs;
    cyc++;
    if (i_rst) begin
      exp_q.delete();
      accepted   = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    hs   = i_valid && i_ready;
    word = {o_man[23], o_exp, o_man[22:0]};
    check("ready_rule", 32'(i_ready), 32'((!o_valid) || (o_ready && o_last)));
    check("valid_vs_queue", 32'(o_valid), 32'(exp_q.size() != 0));
    if (accepted) check("latency_idx0", 32'({o_valid, o_idx}), 32'({1'b1, 4'd0}));
    if (prev_stall) begin
      check("stall_word", word, prev_word);
      check("stall_idx_last", 32'({o_valid, o_idx, o_last}), 32'({1'b1, prev_idx, prev_last}));
    end
    if (!o_valid) begin
      check("idle_data", 32'({o_exp, o_man}), 32'd0);
      check("idle_last", 32'({o_idx, o_last}), 32'd0);
    end else begin
      vcount++;
      if (vfirst < 0) vfirst = cyc;
      vlast = cyc;
      if (i_ready) rdy_pulses++;
      check("last_flag", 32'(o_last), 32'(o_idx == 4'(G - 1)));
      if (o_ready && exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("elem_word", word, x.word);
        check("elem_idx", 32'(o_idx), 32'(x.idx));
        seen_q.push_back(word);
      end
    end
    prev_stall = o_valid && !o_ready;
    prev_word  = word;
    prev_idx   = o_idx;
    prev_last  = o_last;
    if (hs) begin
      for (int j = 0; j < G; j++) exp_q.push_back('{expand(i_bfp_exp, i_bfps[j]), j});
    end
    accepted = hs;
  endtask

  task automatic cycle();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] e, input logic [3:0] el [G]);
    i_bfp_exp = e;
    for (int j = 0; j < G; j++) i_bfps[j] = el[j];
    i_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 300);
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 1'b0;
    while (exp_q.size() != 0 && n < 400) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    cycle();
  endtask

  logic [3:0]  spec_el [G];
  logic [31:0] spec_w  [G];
  logic [3:0]  grp     [G];
  int          rt_e    [G];
  int          rt_f    [G];
  logic        rt_s    [G];

  initial begin
    int n, maxe, d, m;
    logic stall_done;
    real xin, xout, sc;

    i_rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; i_bfp_exp = '0;
    for (int j = 0; j < G; j++) i_bfps[j] = '0;
    repeat (3) cycle();
    i_rst = 1'b0;
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd1);
    check("rst_idx_last", 32'({o_idx, o_last}), 32'd0);
    check("rst_data", 32'({o_exp, o_man}), 32'd0);

    vecs.push_back('{8'd130, 4'b0100, 32'h40800000});
    vecs.push_back('{8'd130, 4'b1011, 32'hC0400000});
    vecs.push_back('{8'd130, 4'b0001, 32'h3F800000});
    vecs.push_back('{8'd130, 4'b1000, 32'h80000000});
    vecs.push_back('{8'd130, 4'b0010, 32'h40000000});
    vecs.push_back('{8'd2,   4'b0001, 32'h00000000});
    vecs.push_back('{8'd2,   4'b0100, 32'h00800000});
    vecs.push_back('{8'd1,   4'b0100, 32'h00000000});
    vecs.push_back('{8'd0,   4'b1101, 32'h80000000});
    vecs.push_back('{8'd0,   4'b0111, 32'h00000000});
    vecs.push_back('{8'd255, 4'b0100, 32'h7F000000});
    vecs.push_back('{8'd3,   4'b0001, 32'h00000000});
    vecs.push_back('{8'd4,   4'b0001, 32'h00800000});
    vecs.push_back('{8'd4,   4'b1011, 32'h81400000});
    foreach (vecs[v]) begin
      for (int j = 0; j < G; j++) grp[j] = vecs[v].el;
      seen_q.delete();
      load(vecs[v].e, grp);
      wait_accept();
      drain();
      check("vec_count", 32'(seen_q.size()), 32'(G));
      for (int j = 0; j < seen_q.size(); j++) check("vec_word", seen_q[j], vecs[v].word);
    end

    for (int j = 0; j < G; j++) begin spec_el[j] = 4'b0010; spec_w[j] = 32'h40000000; end
    spec_el[0] = 4'b0100; spec_w[0] = 32'h40800000;
    spec_el[1] = 4'b1011; spec_w[1] = 32'hC0400000;
    spec_el[2] = 4'b0001; spec_w[2] = 32'h3F800000;
    spec_el[3] = 4'b1000; spec_w[3] = 32'h80000000;
    seen_q.delete();
    load(8'd130, spec_el);
    wait_accept();
    drain();
    check("spec_count", 32'(seen_q.size()), 32'(G));
    for (int j = 0; j < seen_q.size(); j++) check("spec_word", seen_q[j], spec_w[j]);

    // Stall three cycles while element 5 is on the output
    seen_q.delete();
    load(8'd130, spec_el);
    wait_accept();
    i_valid = 1'b0;
    stall_done = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (o_valid && o_idx == 4'd5 && !stall_done) begin
        o_ready = 1'b0;
        repeat (3) cycle();
        o_ready = 1'b1;
        stall_done = 1'b1;
      end else begin
        cycle();
      end
      n++;
    end
    drain();
    check("stall_seen", 32'(stall_done), 32'd1);
    check("stall_count", 32'(seen_q.size()), 32'(G));
    for (int j = 0; j < seen_q.size(); j++) check("stall_word", seen_q[j], spec_w[j]);

    // Three groups back to back with i_valid held
    vcount = 0; vfirst = -1; vlast = -1; rdy_pulses = 0;
    seen_q.delete();
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < G; j++) grp[j] = 4'($urandom);
      load(8'($urandom_range(1, 255)), grp);
      wait_accept();
    end
    drain();
    check("b2b_valid_cycles", 32'(vcount), 32'd48);
    check("b2b_contiguous", 32'(vlast - vfirst + 1), 32'd48);
    check("b2b_ready_pulses", 32'(rdy_pulses), 32'd3);
    check("b2b_count", 32'(seen_q.size()), 32'd48);

    // Reset while element 7 is presented
    load(8'd130, spec_el);
    wait_accept();
    i_valid = 1'b0;
    n = 0;
    while (!(o_valid && o_idx == 4'd7) && n < 50) begin cycle(); n++; end
    check("reach_idx7", 32'(o_idx), 32'd7);
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    #1;
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_i_ready", 32'(i_ready), 32'd1);
    seen_q.delete();
    load(8'd130, spec_el);
    wait_accept();
    drain();
    check("postrst_count", 32'(seen_q.size()), 32'(G));
    if (seen_q.size() > 1) begin
      check("postrst_w0", seen_q[0], spec_w[0]);
      check("postrst_w1", seen_q[1], spec_w[1]);
    end

    // Random groups with random backpressure, checked by the scoreboard
    i_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!i_valid && ($urandom % 3) == 0) begin
        for (int j = 0; j < G; j++) grp[j] = 4'($urandom);
        load(8'($urandom), grp);
      end
      o_ready = ($urandom % 4) != 0;
      cycle();
      if (accepted) i_valid = 1'b0;
    end
    o_ready = 1'b1;
    drain();

    // Round trip through a model of the block-floating-point converter
    for (int r = 0; r < 6; r++) begin
      maxe = $urandom_range(100, 150);
      for (int j = 0; j < G; j++) begin
        rt_s[j] = 1'($urandom);
        rt_f[j] = int'($urandom % (1 << 23));
        rt_e[j] = (j == r) ? maxe : maxe - int'($urandom_range(0, 5));
        d = maxe - rt_e[j];
        m = (((1 << 23) + rt_f[j]) + (1 << (20 + d))) >> (21 + d);
        if (m > 7) m = 7;
        grp[j] = {rt_s[j], 3'(m)};
      end
      seen_q.delete();
      load(8'(maxe + 1), grp);
      wait_accept();
      drain();
      check("rt_count", 32'(seen_q.size()), 32'(G));
      for (int j = 0; j < seen_q.size(); j++) begin
        if (rt_e[j] == maxe) begin
          xin = 1.0 + real'(rt_f[j]) / 8388608.0;
          sc = 1.0;
          for (int t = 0; t < int'(seen_q[j][30:23]) - maxe; t++) sc = sc * 2.0;
          for (int t = 0; t < maxe - int'(seen_q[j][30:23]); t++) sc = sc / 2.0;
          xout = (seen_q[j][30:23] == 8'd0) ? 0.0 :
                 (1.0 + real'(seen_q[j][22:0]) / 8388608.0) * sc;
          check("rt_sign", 32'(seen_q[j][31]), 32'(rt_s[j]));
          check("rt_relerr_ok", 32'((xout - xin) <= xin / 8.0 && (xin - xout) <= xin / 8.0), 32'd1);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bfp_deconverter.md
# bfp_deconverter

Block-floating-point to floating-point expander. It sits on the read-back side of `bfp_converter`: it accepts one BFP group per handshake, a shared exponent plus GRPSIZE sign/mantissa elements. It then streams the group out as GRPSIZE normalized FP elements, one per cycle, in the same split exponent / {sign, mantissa} format that `bfp_converter` consumes. Both sides use valid/ready handshakes with output backpressure. Back-to-back groups run without bubbles.

## Interface

Parameters:
- GRPSIZE, 16, elements per group; power of two, ≥2
- FPEXPSIZE, 8, FP exponent width
- FPMANSIZE, 23, FP stored-mantissa width (no implicit bit)
- BFPEXPSIZE, 8, shared-exponent width; must equal FPEXPSIZE
- BFPMANSIZE, 3, BFP element mantissa width; must be ≤ FPMANSIZE

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  input group valid
- i_ready  output  1  block can accept a group this cycle
- i_bfp_exp  input  BFPEXPSIZE  shared exponent E
- i_bfps  input  [BFPMANSIZE+1]×GRPSIZE (unpacked [0:GRPSIZE-1])  element {sign, m}
- o_valid  output  1  output element valid
- o_ready  input  1  downstream accepts element
- o_exp  output  FPEXPSIZE  FP biased exponent
- o_man  output  FPMANSIZE+1  {sign, stored mantissa}
- o_idx  output  $clog2(GRPSIZE)  element index within group
- o_last  output  1  high with element GRPSIZE-1

## Operation

- Element value semantics: 0.m × 2^(E−bias), where m is BFPMANSIZE bits, MSB weight ½. E=0 means the whole group is zero.
- Conversion per element, combinational from the captured registers:
  - k = 1 + count of leading zeros in m (1..BFPMANSIZE).
  - m==0, or E==0, or E ≤ k: output o_exp=0 and mantissa 0. The sign bit is kept (signed zero). This flushes underflow; no denormals are produced.
  - Otherwise: o_exp = E − k. The stored mantissa is the bits of m below its leading one, left-aligned into FPMANSIZE bits, with zeros filling the low bits.
- Sign passes through unchanged in all cases.
- FSM states:
  - IDLE: i_ready=1, o_valid=0. When i_valid is high, capture E and all elements, set idx=0, go to DRAIN.
  - DRAIN: o_valid=1 and the element at idx is presented. When o_ready is high, idx increments.
  - When o_ready is high and o_last is high:
    - If i_valid is also high, capture the new group, set idx=0, and stay in DRAIN.
    - Otherwise go to IDLE.
- i_ready = (state==IDLE) | (o_valid & o_ready & o_last). This is the only combinational input-to-output path (o_ready → i_ready).
- idx wraps GRPSIZE-1 → 0 only on a group boundary.
- While o_valid=1 and o_ready=0, o_exp, o_man, o_idx and o_last hold stable.
- Captured group registers change only on an accepted input handshake.

## Timing

- Reset values: state=IDLE, o_valid=0, idx=0, o_idx=0, o_last=0, o_exp=0, o_man=0.
  - Data outputs are forced to 0 while o_valid=0.
  - i_ready is 1 in the first cycle after reset deasserts.
- Latency: a group accepted at edge N presents element 0 in the cycle after edge N.
- Throughput: with o_ready held high, one element per cycle and GRPSIZE cycles per group, with no bubble between groups.
- Reset mid-DRAIN: the group in flight is discarded. The cycle after reset has o_valid=0 and the block is in IDLE.
- i_valid with i_ready=0: input is ignored. The source must hold it until it is accepted.

## Test plan

- Default parameters, E=130, elements[0..3] = {0,100}, {1,011}, {0,001}, {1,000}; all others {0,010}.
  - Required outputs: 0x40800000 (4.0), 0xC0400000 (−3.0), 0x3F800000 (1.0), 0x80000000 (−0), then 0x40000000 (2.0) ×12.
  - o_last is high only with idx 15. First valid appears 1 cycle after the input handshake.
- Underflow, E=2: {0,001} → 0x00000000 and {0,100} → exp 1, i.e. 0x00800000.
  - E=1: {0,100} → 0x00000000.
  - E=0: any element → signed zero.
- Backpressure: drop o_ready for 3 cycles at idx 5 → outputs hold stable. No element is skipped or duplicated, and the 16 elements still arrive in order.
- Back-to-back: i_valid held high with 3 groups and o_ready=1 → 48 consecutive valid cycles. i_ready pulses only on each o_last beat.
- Reset mid-drain: assert i_rst at idx 7 for 1 cycle.
  - Next cycle: o_valid=0, i_ready=1.
  - A new group then starts at idx 0 with the correct values.
- Round-trip: random FP32 groups → `bfp_converter` → this block. The result must equal the converter output re-expanded per the rules above.
  - For inputs whose exponent equals the group maximum, the relative error is ≤ 2^−3.
